// File: rtl/nibble_pkg.sv
// Shared types and constants for the two-requester nibble serializer.
package nibble_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    localparam int NIBBLE_W = 4;

    localparam logic SRC_A = 1'b1;
    localparam logic SRC_B = 1'b0;

endpackage : nibble_pkg

// File: rtl/nibble_mux.sv
// Combinational nibble select: returns word[idx*4 +: 4], LSB nibble at idx 0.
module nibble_mux
    import nibble_pkg::*;
#(
    parameter int NIBBLES = 8,
    localparam int IDX_W = $clog2(NIBBLES)
) (
    input  logic [NIBBLE_W*NIBBLES-1:0] word,
    input  logic [IDX_W-1:0]            idx,
    output logic [NIBBLE_W-1:0]         nibble
);

    logic [NIBBLE_W-1:0] lanes [NIBBLES];

    generate
        for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_lane
            assign lanes[gi] = word[gi*NIBBLE_W +: NIBBLE_W];
        end
    endgenerate

    assign nibble = lanes[idx];

endmodule : nibble_mux

// File: rtl/nibble_arbiter.sv
// Round-robin arbiter between two word requesters; streams the winning word
// out one nibble at a time with back-to-back capture on the last nibble.
module nibble_arbiter
    import nibble_pkg::*;
#(
    parameter int NIBBLES = 8,
    localparam int IDX_W = $clog2(NIBBLES),
    localparam int WORD_W = NIBBLE_W * NIBBLES
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                reqA,
    input  logic [WORD_W-1:0]   dataA,
    output logic                ackA,
    input  logic                reqB,
    input  logic [WORD_W-1:0]   dataB,
    output logic                ackB,
    input  logic                out_ready,
    output logic [NIBBLE_W-1:0] nibble_out,
    output logic                nibble_valid,
    output logic                nibble_src,
    output logic [IDX_W-1:0]    nibble_idx,
    output logic                busy
);

    state_t              state_q, state_d;
    logic [WORD_W-1:0]   word_q, word_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                src_q, src_d;
    logic                ack_a_q, ack_a_d;
    logic                ack_b_q, ack_b_d;
    logic                last_a_q, last_a_d;
    logic [NIBBLE_W-1:0] nibble_q, nibble_d;

    logic accept;
    logic last_nibble;
    logic capture;
    logic grant_a;
    logic grant_b;

    assign accept      = (state_q == STREAM) && out_ready;
    assign last_nibble = (idx_q == IDX_W'(NIBBLES - 1));
    assign capture     = (reqA || reqB) && ((state_q == IDLE) || (accept && last_nibble));

    // last_a_q clear means B was served last, so A takes a tie out of reset.
    assign grant_a = reqA && (!reqB || !last_a_q);
    assign grant_b = reqB && !grant_a;

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
        src_d    = src_q;
        ack_a_d  = 1'b0;
        ack_b_d  = 1'b0;
        last_a_d = last_a_q;

        if (capture) begin
            state_d  = STREAM;
            word_d   = grant_a ? dataA : dataB;
            idx_d    = '0;
            src_d    = grant_a ? SRC_A : SRC_B;
            ack_a_d  = grant_a;
            ack_b_d  = grant_b;
            last_a_d = grant_a;
        end else if (accept) begin
            if (last_nibble) begin
                state_d = IDLE;
                idx_d   = '0;
            end else begin
                idx_d = idx_q + IDX_W'(1);
            end
        end
    end

    // Select from the next-state word/index so nibble_out lines up with nibble_idx.
    nibble_mux #(
        .NIBBLES (NIBBLES)
    ) u_mux (
        .word   (word_d),
        .idx    (idx_d),
        .nibble (nibble_d)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            word_q   <= '0;
            idx_q    <= '0;
            src_q    <= 1'b0;
            ack_a_q  <= 1'b0;
            ack_b_q  <= 1'b0;
            last_a_q <= 1'b0;
            nibble_q <= '0;
        end else begin
            state_q  <= state_d;
            word_q   <= word_d;
            idx_q    <= idx_d;
            src_q    <= src_d;
            ack_a_q  <= ack_a_d;
            ack_b_q  <= ack_b_d;
            last_a_q <= last_a_d;
            nibble_q <= nibble_d;
        end
    end

    assign ackA         = ack_a_q;
    assign ackB         = ack_b_q;
    assign nibble_out   = nibble_q;
    assign nibble_valid = (state_q == STREAM);
    assign nibble_src   = src_q;
    assign nibble_idx   = idx_q;
    assign busy         = (state_q == STREAM);

endmodule : nibble_arbiter

// File: doc/nibble_arbiter.md
NIBBLE_ARBITER -- requirements
Module: nibble_arbiter

Interface
REQ-001 SHALL have parameter NIBBLES, default 8, giving nibbles per word; legal values are powers of two from 2 to 8.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset, input, 1, a synchronous active-high reset.
REQ-004 SHALL have port reqA, input, 1, requester A has a word pending.
REQ-005 SHALL have port dataA, input, 4*NIBBLES, requester A word; held stable while reqA=1 and until ackA.
REQ-006 SHALL have port ackA, output, 1, one-cycle pulse meaning dataA was captured.
REQ-007 SHALL have ports reqB, dataB and ackB, identical to the A ports but for requester B.
REQ-008 SHALL have port out_ready, input, 1, downstream accepts the current nibble.
REQ-009 SHALL have port nibble_out, output, 4, the current nibble.
REQ-010 SHALL have port nibble_valid, output, 1, nibble_out is valid.
REQ-011 SHALL have port nibble_src, output, 1, source of the current word: 1=A, 0=B.
REQ-012 SHALL have port nibble_idx, output, log2(NIBBLES), index of nibble_out within its word.
REQ-013 SHALL have port busy, output, 1, high whenever the state is STREAM.

Function
REQ-014 SHALL implement an FSM with states IDLE and STREAM; every output SHALL come from registers with no combinational path from any input.
REQ-015 Capture event: an edge where state=IDLE and reqA|reqB=1, or where the last nibble is accepted and reqA|reqB=1.
REQ-016 On a capture event, SHALL latch the winner's data into the word register, set idx=0, set nibble_src, pulse the winner's ack for exactly the following cycle, and enter or remain in STREAM.
REQ-017 Arbitration SHALL be round-robin: with a single requester, that requester wins; with both, the requester not served last wins; after reset, A wins a tie.
REQ-018 In STREAM, SHALL drive nibble_valid=1 and nibble_out=word[idx*4 +: 4], LSB nibble first.
REQ-019 Nibble acceptance occurs at an edge where nibble_valid=1 and out_ready=1; only then does idx increment.
REQ-020 While out_ready=0, SHALL hold nibble_out, nibble_idx and nibble_src stable.
REQ-021 On acceptance of nibble NIBBLES-1 with no request pending, SHALL go to IDLE with nibble_valid=0 the next cycle.
REQ-022 On acceptance of nibble NIBBLES-1 with a request pending, SHALL capture back-to-back, giving zero bubble; throughput is one word per NIBBLES cycles when out_ready=1.
REQ-023 Latency: with reqA asserted in IDLE at cycle N, SHALL assert ackA and the first valid nibble in cycle N+1.
REQ-024 SHALL ignore requests during STREAM except at the last-nibble acceptance edge; the losing requester keeps req asserted and is served next.
REQ-025 SHALL never assert ackA and ackB in the same cycle.
REQ-026 SHALL never assert an ack to a requester whose req was 0 at the capture edge.

Reset
REQ-027 When reset=1 at an edge, SHALL set state=IDLE, ackA=ackB=0, nibble_valid=0, nibble_out=0, nibble_idx=0, nibble_src=0, busy=0, word register=0, and round-robin pointer so that A wins the next tie.
REQ-028 Reset during STREAM SHALL abandon the word silently, with no ack and no further nibbles; reset has priority over a simultaneous capture.

Structure
REQ-029 SHALL place the state encoding (IDLE, STREAM), the nibble width constant 4, and the source encoding (SRC_A=1, SRC_B=0) in a shared package, nibble_pkg.
REQ-030 SHALL implement nibble extraction in the sub-module nibble_mux (word, idx -> 4-bit nibble, combinational) and register its output in nibble_arbiter.
REQ-031 SHALL keep the arbitration and round-robin pointer in nibble_arbiter itself.

Verification
REQ-032 Single word: reqA=1, dataA=0x87654321, out_ready=1 -> ackA pulses at N+1; nibbles 1,2,3,4,5,6,7,8 appear on idx 0..7 with src=1; then IDLE.
REQ-033 Tie after reset: reqA=reqB=1, dataA=0xAAAAAAAA, dataB=0x55555555 -> A streams first; B is captured back-to-back with no valid gap; then with both still requesting, A wins again.
REQ-034 Stall: during A's stream, out_ready=0 for 3 cycles at idx=2 -> nibble_out=idx-2 value held for 4 cycles total; stream resumes at idx=3; total 11 valid cycles.
REQ-035 Reset mid-stream: reset=1 at idx=4 -> nibble_valid=0, busy=0 next cycle; no ack; after release, a pending reqB is served with ackB.
REQ-036 Back-to-back same requester: reqB held through two words 0x0000000F and 0xF0000000 -> ackB pulses twice, 8 cycles apart; 16 consecutive valid cycles.
REQ-037 Every scenario SHALL check that ackA and ackB are never asserted together and that nibble_out is stable whenever nibble_valid=1 and out_ready=0.
